// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller.
//   DATA_TYPE / ZERO_WORD : 32-bit data word and its zero value
//   RAM_IO_PORT           : default base address of the 8-byte IO window
//   SIZE_B/H/W            : access sizes in bytes
//   state_t               : controller FSM states
//   req_t                 : one latched client request
//   norm_size()           : maps a raw 6-bit size onto 1, 2 or 4
package mem_ctrl_pkg;

  typedef logic [31:0] DATA_TYPE;

  localparam DATA_TYPE    ZERO_WORD   = 32'h0;
  localparam logic [31:0] RAM_IO_PORT = 32'h30000;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        sgn;
    DATA_TYPE    data;
  } req_t;

  // Anything other than 1 or 2 is a full word.
  function automatic logic [2:0] norm_size(input logic [5:0] s);
    case (s)
      6'd1:    return SIZE_B;
      6'd2:    return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Byte assembly plus sign/zero extension of read data.
//   bytes : 4 bytes, bytes[0] at the lowest address
//   size  : 1, 2 or 4 (normalised)
//   sgn   : 1 = sign-extend sub-word results
//   word  : extended 32-bit result
module mem_extend
  import mem_ctrl_pkg::*;
(
  input  logic [3:0][7:0] bytes,
  input  logic [2:0]      size,
  input  logic            sgn,
  output DATA_TYPE        word
);

  always_comb begin
    case (size)
      SIZE_B:  word = {{24{sgn & bytes[0][7]}}, bytes[0]};
      SIZE_H:  word = {{16{sgn & bytes[1][7]}}, bytes[1], bytes[0]};
      default: word = bytes;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller between the byte-wide RAM/IO bus and the fetcher,
// load/store buffer (loads) and ROB (committed stores).
// Requests are latched into per-client slots, arbitrated store > load >
// fetch, and serialised into 1/2/4 single-byte bus transfers.
//   clk, rst (sync, active-low), rdy (global freeze)
//   in_rob_xbp          : mispredict flush (kills fetch/load only)
//   in/out_fetch_*      : instruction fetch request / 32-bit word
//   in/out_lsb_*        : load request / extended data
//   in/out_rob_*        : store request / done
//   mem_din/dout/a/wr   : RAM byte bus
//   io_buffer_full      : stalls stores that target the IO window
// Build option MEM_CTRL_PERF_EN adds out_perf_busy / out_perf_stall.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = RAM_IO_PORT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_rob_xbp,
  input  logic              in_fetch_flag,
  input  logic [ADDR_W-1:0] in_fetch_addr,
  output logic              out_fetch_flag,
  output logic [31:0]       out_fetch_data,
  input  logic              in_lsb_flag,
  input  logic [5:0]        in_lsb_size,
  input  logic              in_lsb_signed,
  input  logic [ADDR_W-1:0] in_lsb_addr,
  output logic              out_lsb_flag,
  output logic [31:0]       out_lsb_data,
  input  logic              in_rob_flag,
  input  logic [5:0]        in_rob_size,
  input  logic [ADDR_W-1:0] in_rob_addr,
  input  logic [31:0]       in_rob_data,
  output logic              out_rob_flag,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
`ifdef MEM_CTRL_PERF_EN
  ,
  output logic [31:0]       out_perf_busy,
  output logic [31:0]       out_perf_stall
`endif
);

  state_t          state;
  req_t            f_req, l_req, s_req;     // pending slots
  req_t            f_nxt, l_nxt, s_nxt;     // slot or same-edge pulse
  req_t            sel, cur;                // arbitration winner / active transfer
  logic            f_vld, l_vld, s_vld;
  logic            f_any, l_any, s_any;
  logic            s_io, s_ok, l_ok, f_ok;
  logic [2:0]      cnt;                     // i during the cycle after Ei
  logic [3:0][7:0] rd_bytes, asm_bytes;
  logic            wr_q;
  DATA_TYPE        ext_word;

  always_comb begin
    f_any = f_vld | in_fetch_flag;
    l_any = l_vld | in_lsb_flag;
    s_any = s_vld | in_rob_flag;
    // A full slot shadows any new pulse for that client.
    f_nxt = f_vld ? f_req : '{addr: in_fetch_addr, size: SIZE_W, sgn: 1'b0, data: ZERO_WORD};
    l_nxt = l_vld ? l_req : '{addr: in_lsb_addr, size: norm_size(in_lsb_size),
                              sgn: in_lsb_signed, data: ZERO_WORD};
    s_nxt = s_vld ? s_req : '{addr: in_rob_addr, size: norm_size(in_rob_size),
                              sgn: 1'b0, data: in_rob_data};
    // Unsigned offset test covers IO_BASE..IO_BASE+7 without overflow corner cases.
    s_io  = (s_nxt.addr - IO_BASE) < 32'd8;
    s_ok  = s_any & ~(s_io & io_buffer_full);
    l_ok  = l_any & ~in_rob_xbp;
    f_ok  = f_any & ~in_rob_xbp;
    sel   = s_ok ? s_nxt : (l_ok ? l_nxt : f_nxt);
    // Final byte arrives on mem_din at the done edge; fold it in here.
    asm_bytes = rd_bytes;
    asm_bytes[cnt[1:0] - 2'd1] = mem_din;
  end

  mem_extend u_ext (
    .bytes (asm_bytes),
    .size  (cur.size),
    .sgn   (cur.sgn),
    .word  (ext_word)
  );

  assign mem_wr = wr_q & rdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      f_vld          <= 1'b0;
      l_vld          <= 1'b0;
      s_vld          <= 1'b0;
      f_req          <= '0;
      l_req          <= '0;
      s_req          <= '0;
      cur            <= '0;
      cnt            <= '0;
      rd_bytes       <= '0;
      wr_q           <= 1'b0;
      mem_a          <= '0;
      mem_dout       <= '0;
      out_fetch_flag <= 1'b0;
      out_lsb_flag   <= 1'b0;
      out_rob_flag   <= 1'b0;
      out_fetch_data <= '0;
      out_lsb_data   <= '0;
    end else if (rdy) begin
      out_fetch_flag <= 1'b0;
      out_lsb_flag   <= 1'b0;
      out_rob_flag   <= 1'b0;
      f_vld <= f_any & ~in_rob_xbp;
      l_vld <= l_any & ~in_rob_xbp;
      s_vld <= s_any;
      f_req <= f_nxt;
      l_req <= l_nxt;
      s_req <= s_nxt;
      case (state)
        IDLE: begin
          if (s_ok) begin
            s_vld    <= 1'b0;
            state    <= STORE;
            wr_q     <= 1'b1;
            mem_dout <= s_nxt.data[7:0];
          end else if (l_ok) begin
            l_vld <= 1'b0;
            state <= LOAD;
          end else if (f_ok) begin
            f_vld <= 1'b0;
            state <= FETCH;
          end
          if (s_ok | l_ok | f_ok) begin
            cur   <= sel;
            mem_a <= sel.addr;
            cnt   <= 3'd1;
          end
        end
        default: begin
          if (in_rob_xbp && state != STORE) begin
            state <= IDLE;
            mem_a <= '0;
          end else begin
            rd_bytes <= asm_bytes;
            if (cnt == cur.size) begin
              state <= IDLE;
              wr_q  <= 1'b0;
              mem_a <= '0;
              if (state == LOAD) begin
                out_lsb_flag <= 1'b1;
                out_lsb_data <= ext_word;
              end else if (state == FETCH) begin
                out_fetch_flag <= 1'b1;
                out_fetch_data <= ext_word;
              end else begin
                out_rob_flag <= 1'b1;
              end
            end else begin
              mem_a    <= cur.addr + 32'(cnt);
              mem_dout <= cur.data[{cnt[1:0], 3'b000} +: 8];
              cnt      <= cnt + 3'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef MEM_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_perf_busy  <= '0;
      out_perf_stall <= '0;
    end else if (rdy) begin
      if (state != IDLE && out_perf_busy != 32'hFFFF_FFFF)
        out_perf_busy <= out_perf_busy + 32'd1;
      if (s_any && s_io && io_buffer_full && out_perf_stall != 32'hFFFF_FFFF)
        out_perf_stall <= out_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl. A transaction-level model predicts,
// per clock edge, the bus address/write activity and done pulses from the
// accept time and size of each request; load/fetch results are computed
// arithmetically from the bench RAM at accept time.
module tb_mem_ctrl;

  logic        clk = 0, rst = 0, rdy = 0, in_rob_xbp = 0;
  logic        in_fetch_flag = 0, in_lsb_flag = 0, in_lsb_signed = 0, in_rob_flag = 0;
  logic [31:0] in_fetch_addr = 0, in_lsb_addr = 0, in_rob_addr = 0, in_rob_data = 0;
  logic [5:0]  in_lsb_size = 0, in_rob_size = 0;
  logic [7:0]  mem_din = 0;
  logic        io_buffer_full = 0;
  logic        out_fetch_flag, out_lsb_flag, out_rob_flag, mem_wr;
  logic [31:0] out_fetch_data, out_lsb_data, mem_a;
  logic [7:0]  mem_dout;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_rob_xbp(in_rob_xbp),
    .in_fetch_flag(in_fetch_flag), .in_fetch_addr(in_fetch_addr),
    .out_fetch_flag(out_fetch_flag), .out_fetch_data(out_fetch_data),
    .in_lsb_flag(in_lsb_flag), .in_lsb_size(in_lsb_size), .in_lsb_signed(in_lsb_signed),
    .in_lsb_addr(in_lsb_addr), .out_lsb_flag(out_lsb_flag), .out_lsb_data(out_lsb_data),
    .in_rob_flag(in_rob_flag), .in_rob_size(in_rob_size), .in_rob_addr(in_rob_addr),
    .in_rob_data(in_rob_data), .out_rob_flag(out_rob_flag),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  localparam int K_F = 1, K_L = 2, K_S = 3;

  int          nchk = 0, nerr = 0;
  int          n_fetch_pulse = 0, n_lsb_pulse = 0, n_rob_pulse = 0;
  int unsigned e = 0, t0 = 0, tend = 0;
  bit          pf = 0, pl = 0, ps = 0, lsg = 0, act = 0, abrt = 0;
  int          ln = 0, sn = 0, kind = 0;
  logic [31:0] fa = 0, la = 0, sa = 0, sd = 0, xa = 0, xd = 0, xres = 0;
  logic [31:0] exp_fd = 0, exp_ld = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, want, e);
    end
  endtask

  function automatic int nsize(input logic [5:0] s);
    return (s == 6'd1) ? 1 : (s == 6'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] a, input int n, input bit sg);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(rd(a + 32'(i))) << (8 * i);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic start(input int k, input logic [31:0] a, input int n,
                       input logic [31:0] d, input logic [31:0] res);
    act = 1; abrt = 0; kind = k; t0 = e; tend = e + 32'(n);
    xa = a; xd = d; xres = res;
  endtask

  task automatic model_edge();
    if (!rst) begin
      pf = 0; pl = 0; ps = 0; act = 0; exp_fd = 0; exp_ld = 0;
      return;
    end
    if (!rdy) return;
    e++;
    if (in_fetch_flag && !pf) begin pf = 1; fa = in_fetch_addr; end
    if (in_lsb_flag && !pl) begin
      pl = 1; la = in_lsb_addr; ln = nsize(in_lsb_size); lsg = in_lsb_signed;
    end
    if (in_rob_flag && !ps) begin
      ps = 1; sa = in_rob_addr; sn = nsize(in_rob_size); sd = in_rob_data;
    end
    if (act && !abrt && kind != K_S && e > t0 && e <= tend && in_rob_xbp) begin
      abrt = 1; tend = e;
    end
    if (act && !abrt && e == tend) begin
      if (kind == K_F) exp_fd = xres;
      else if (kind == K_L) exp_ld = xres;
    end
    if (in_rob_xbp) begin pf = 0; pl = 0; end
    if (!act || e > tend) begin
      if (ps && !(io_buffer_full && sa >= 32'h30000 && sa <= 32'h30007)) begin
        ps = 0; start(K_S, sa, sn, sd, 0);
      end else if (pl) begin
        pl = 0; start(K_L, la, ln, 0, load_value(la, ln, lsg));
      end else if (pf) begin
        pf = 0; start(K_F, fa, 4, 0, load_value(fa, 4, 0));
      end
    end
  endtask

  task automatic check_outputs();
    bit inx, ew, done;
    logic [31:0] ea;
    inx  = act && e >= t0 && e < tend;
    ea   = inx ? xa + (e - t0) : 32'h0;
    ew   = rdy && inx && kind == K_S;
    done = act && !abrt && e == tend;
    chk("mem_a", mem_a, ea);
    chk("mem_wr", 32'(mem_wr), 32'(ew));
    if (ew) chk("mem_dout", 32'(mem_dout), (xd >> (8 * (e - t0))) & 32'hFF);
    chk("fetch_flag", 32'(out_fetch_flag), 32'(done && kind == K_F));
    chk("lsb_flag", 32'(out_lsb_flag), 32'(done && kind == K_L));
    chk("rob_flag", 32'(out_rob_flag), 32'(done && kind == K_S));
    chk("fetch_data", out_fetch_data, exp_fd);
    chk("lsb_data", out_lsb_data, exp_ld);
    n_fetch_pulse += int'(out_fetch_flag);
    n_lsb_pulse   += int'(out_lsb_flag);
    n_rob_pulse   += int'(out_rob_flag);
  endtask

  // One clock: RAM write/read emulation, edge, model update, check.
  task automatic step();
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din = rd(mem_a);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    in_fetch_flag = 0; in_lsb_flag = 0; in_rob_flag = 0; in_rob_xbp = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    in_fetch_flag = 1; in_fetch_addr = a;
  endtask

  task automatic load(input logic [31:0] a, input logic [5:0] sz, input bit sg);
    in_lsb_flag = 1; in_lsb_addr = a; in_lsb_size = sz; in_lsb_signed = sg;
  endtask

  task automatic store(input logic [31:0] a, input logic [5:0] sz, input logic [31:0] d);
    in_rob_flag = 1; in_rob_addr = a; in_rob_size = sz; in_rob_data = d;
  endtask

  task automatic clr_pulses();
    n_fetch_pulse = 0; n_lsb_pulse = 0; n_rob_pulse = 0;
  endtask

  function automatic logic [31:0] raddr();
    case ($urandom_range(5))
      0, 1, 2: return 32'h1000 + 32'($urandom_range(255));
      3:       return 32'h30000 + 32'($urandom_range(9));
      4:       return 32'hFFFF_FFFC + 32'($urandom_range(3));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] rsize();
    case ($urandom_range(5))
      0:       return 6'd1;
      1:       return 6'd2;
      2, 3:    return 6'd4;
      4:       return 6'd3;
      default: return 6'($urandom_range(63));
    endcase
  endfunction

  initial begin
    // Reset
    rst = 0; rdy = 1;
    step(); step();
    rst = 1;
    step();

    // Fetch of 13 00 00 00
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    clr_pulses();
    fetch(32'h100);
    repeat (6) step();
    chk("tp_fetch_word", out_fetch_data, 32'h0000_0013);
    chk("tp_fetch_once", 32'(n_fetch_pulse), 32'd1);

    // Byte / halfword loads with extension
    ram[32'h200] = 8'h80;
    load(32'h200, 6'd1, 1); repeat (4) step();
    chk("tp_lb", out_lsb_data, 32'hFFFF_FF80);
    load(32'h200, 6'd1, 0); repeat (4) step();
    chk("tp_lbu", out_lsb_data, 32'h0000_0080);
    ram[32'h210] = 8'h34; ram[32'h211] = 8'hF2;
    load(32'h210, 6'd2, 1); repeat (5) step();
    chk("tp_lh", out_lsb_data, 32'hFFFF_F234);

    // Word store
    clr_pulses();
    store(32'h400, 6'd4, 32'hDEAD_BEEF);
    repeat (7) step();
    chk("tp_sw_mem", {ram[32'h403], ram[32'h402], ram[32'h401], ram[32'h400]}, 32'hDEAD_BEEF);
    chk("tp_sw_done", 32'(n_rob_pulse), 32'd1);

    // Simultaneous store, load, fetch
    clr_pulses();
    store(32'h500, 6'd2, 32'h0000_1234);
    load(32'h600, 6'd4, 1);
    fetch(32'h700);
    repeat (14) step();
    chk("tp_three_done", 32'(n_fetch_pulse + n_lsb_pulse + n_rob_pulse), 32'd3);

    // IO store stalled behind a full buffer while a fetch proceeds
    clr_pulses();
    io_buffer_full = 1;
    store(32'h30000, 6'd1, 32'h0000_00A5);
    fetch(32'h800);
    repeat (10) step();
    chk("tp_io_stalled", 32'(n_rob_pulse), 32'd0);
    io_buffer_full = 0;
    repeat (4) step();
    chk("tp_io_done", 32'(n_rob_pulse), 32'd1);

    // Flush two edges into a word load with a store pending
    clr_pulses();
    load(32'h900, 6'd4, 1); step();
    store(32'hA00, 6'd4, 32'h0102_0304); step();
    in_rob_xbp = 1; step();
    repeat (8) step();
    chk("tp_flush_no_ld", 32'(n_lsb_pulse), 32'd0);
    chk("tp_flush_st", 32'(n_rob_pulse), 32'd1);

    // Reset in the middle of a store
    clr_pulses();
    store(32'hB00, 6'd4, 32'hCAFE_F00D);
    step(); step();
    rst = 0; step();
    chk("tp_rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("tp_rst_lsb_data", out_lsb_data, 32'd0);
    rst = 1;
    repeat (6) step();
    chk("tp_rst_no_done", 32'(n_rob_pulse), 32'd0);

    // Randomised traffic
    repeat (3000) begin
      rdy            = ($urandom_range(9) != 0);
      io_buffer_full = ($urandom_range(2) == 0);
      rst            = ($urandom_range(499) != 0);
      if ($urandom_range(3) == 0) fetch(raddr());
      if ($urandom_range(3) == 0) load(raddr(), rsize(), 1'($urandom_range(1)));
      if ($urandom_range(4) == 0) store(raddr(), rsize(), $urandom);
      in_rob_xbp = ($urandom_range(24) == 0);
      step();
    end
    rst = 1; rdy = 1; io_buffer_full = 0;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
